frame_accumulator: RTL and testbench

Streaming accumulator that sits directly downstream of the team's ripple_carry_adder and consumes its sum and carry_out.
- Accepts WIDTH-bit samples on a valid/ready input stream.
- Adds each sample to a running total through one ripple_carry_adder #(WIDTH) instance.
- After COUNT samples, presents the frame total and a sticky overflow flag on a valid/ready output stream.
- Used wherever a fixed-length block sum is needed ahead of downstream datapath logic.

---
 rtl/frame_accumulator.sv | 99 +++++++++
 tb/tb_frame_accumulator.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_accumulator.sv
// Fixed-length block summer: adds COUNT unsigned samples through a ripple-carry adder and
// hands the wrapped total plus a sticky carry flag to a valid/ready consumer.

module ripple_carry_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic carry;

  always_comb begin
    carry = carry_in;
    sum   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum[i] = in0[i] ^ in1[i] ^ carry;
      carry  = (in0[i] & in1[i]) | (carry & (in0[i] ^ in1[i]));
    end
    carry_out = carry;
  end

endmodule

module frame_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow
);

  localparam int unsigned CW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] next_acc;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             c;
  logic             accept;
  logic             drain;

  ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .in0      (acc),
    .in1      (in_data),
    .carry_in (1'b0),
    .sum      (next_acc),
    .carry_out(c)
  );

  // Ready ignores in_valid so the producer never sees a combinational loop through us.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (drain) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (cnt == LAST) begin
          // Frame end wins over a same-cycle drain, so back-to-back results keep flowing.
          out_sum      <= next_acc;
          out_overflow <= ovf | c;
          out_valid    <= 1'b1;
          acc          <= '0;
          ovf          <= 1'b0;
          cnt          <= '0;
        end else begin
          acc <= next_acc;
          ovf <= ovf | c;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Bench for frame_accumulator: directed scenarios plus random traffic on a COUNT=4 and a
// COUNT=1 instance, both checked every cycle against an integer-sum reference model.

module tb_frame_accumulator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid[2];
  logic       in_ready[2];
  logic [W-1:0] in_data[2];
  logic       out_valid[2];
  logic       out_ready[2];
  logic [W-1:0] out_sum[2];
  logic       out_overflow[2];

  int passed = 0;
  int total  = 0;

  // Reference model: plain integer frame total, result register with last-value hold.
  int m_total[2];
  int m_n[2];
  int m_sum[2];
  bit m_valid[2];
  bit m_ovf[2];
  bit took[2];
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  frame_accumulator #(
    .WIDTH(W),
    .COUNT(4)
  ) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid[0]),
    .in_ready    (in_ready[0]),
    .in_data     (in_data[0]),
    .out_valid   (out_valid[0]),
    .out_ready   (out_ready[0]),
    .out_sum     (out_sum[0]),
    .out_overflow(out_overflow[0])
  );

  frame_accumulator #(
    .WIDTH(W),
    .COUNT(1)
  ) dut1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid[1]),
    .in_ready    (in_ready[1]),
    .in_data     (in_data[1]),
    .out_valid   (out_valid[1]),
    .out_ready   (out_ready[1]),
    .out_sum     (out_sum[1]),
    .out_overflow(out_overflow[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int frame_len(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  always @(negedge clk) begin
    bit rdy, acc, drn;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_total[k] = 0;
        m_n[k]     = 0;
        m_sum[k]   = 0;
        m_valid[k] = 1'b0;
        m_ovf[k]   = 1'b0;
        took[k]    = 1'b0;
      end else if (chk_en) begin
        rdy = !m_valid[k] || out_ready[k];
        check_eq($sformatf("in_ready%0d", k), in_ready[k], rdy);
        check_eq($sformatf("out_valid%0d", k), out_valid[k], m_valid[k]);
        check_eq($sformatf("out_sum%0d", k), out_sum[k], m_sum[k]);
        check_eq($sformatf("out_overflow%0d", k), out_overflow[k], m_ovf[k]);
        acc     = in_valid[k] && rdy;
        drn     = m_valid[k] && out_ready[k];
        took[k] = acc;
        if (drn) m_valid[k] = 1'b0;
        if (acc) begin
          m_total[k] += int'(in_data[k]);
          m_n[k]++;
          if (m_n[k] == frame_len(k)) begin
            m_sum[k]   = m_total[k] % 256;
            m_ovf[k]   = (m_total[k] >= 256);
            m_valid[k] = 1'b1;
            m_total[k] = 0;
            m_n[k]     = 0;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit v, input logic [W-1:0] d, input bit r);
    in_valid[k]  = v;
    in_data[k]   = d;
    out_ready[k] = r;
  endtask

  task automatic send4(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [W-1:0] d, input bit r);
    drive(0, 1'b1, a, r); step();
    drive(0, 1'b1, b, r); step();
    drive(0, 1'b1, c, r); step();
    drive(0, 1'b1, d, r); step();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) drive(k, 1'b0, '0, 1'b1);
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("post_reset_in_ready", in_ready[0], 1);
    check_eq("post_reset_out_valid", out_valid[0], 0);

    // Simple frame.
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    check_eq("t2_valid", out_valid[0], 1);
    check_eq("t2_sum", out_sum[0], 10);
    check_eq("t2_ovf", out_overflow[0], 0);
    drive(0, 1'b0, '0, 1'b1); step();
    check_eq("t2_valid_one_cycle", out_valid[0], 0);

    // Wrap and per-frame clearing of the sticky flag.
    send4(8'd200, 8'd100, 8'd0, 8'd0, 1'b1);
    check_eq("t3_sum_a", out_sum[0], 44);
    check_eq("t3_ovf_a", out_overflow[0], 1);
    send4(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    check_eq("t3_sum_b", out_sum[0], 4);
    check_eq("t3_ovf_b", out_overflow[0], 0);
    drive(0, 1'b0, '0, 1'b1); step();

    // Backpressure.
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b1, 8'd5, 1'b0); step();
      check_eq("t4_stall_ready", in_ready[0], 0);
      check_eq("t4_stall_sum", out_sum[0], 10);
    end
    out_ready[0] = 1'b1;
    #1;
    check_eq("t4_ready_on_drain", in_ready[0], 1);
    step();
    drive(0, 1'b0, '0, 1'b1);
    check_eq("t4_drained", out_valid[0], 0);

    // Partial frame (5,7,7) discarded by a mid-cycle reset.
    drive(0, 1'b1, 8'd7, 1'b1); step();
    drive(0, 1'b1, 8'd7, 1'b1); step();
    drive(0, 1'b0, '0, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid[0], 0);
    check_eq("rst_out_sum", out_sum[0], 0);
    check_eq("rst_out_ovf", out_overflow[0], 0);
    step();
    rst = 1'b0;
    step();
    check_eq("rst_release_ready", in_ready[0], 1);
    send4(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
    check_eq("t5_sum", out_sum[0], 4);
    check_eq("t5_ovf", out_overflow[0], 0);
    drive(0, 1'b0, '0, 1'b1);

    // COUNT=1 back-to-back.
    drive(1, 1'b1, 8'd9, 1'b1); step();
    check_eq("c1_valid_a", out_valid[1], 1);
    check_eq("c1_sum_a", out_sum[1], 9);
    drive(1, 1'b1, 8'd8, 1'b1); step();
    check_eq("c1_valid_b", out_valid[1], 1);
    check_eq("c1_sum_b", out_sum[1], 8);
    drive(1, 1'b1, 8'd7, 1'b1); step();
    check_eq("c1_valid_c", out_valid[1], 1);
    check_eq("c1_sum_c", out_sum[1], 7);
    check_eq("c1_ovf", out_overflow[1], 0);
    drive(1, 1'b0, '0, 1'b1); step();
    check_eq("c1_valid_end", out_valid[1], 0);

    // Idle gaps inside a frame.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b0, 8'hff, 1'b1);
      repeat ($urandom_range(0, 3)) step();
      drive(0, 1'b1, 8'(i), 1'b1); step();
    end
    check_eq("gap_sum", out_sum[0], 10);
    check_eq("gap_valid", out_valid[0], 1);

    // Random traffic; a stalled producer keeps its sample until it is taken.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!(in_valid[k] && !took[k])) begin
          in_valid[k] = ($urandom_range(0, 3) != 0);
          in_data[k]  = 8'($urandom);
        end
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      if (cyc == 1500) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) in_valid[k] = 1'b0;
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
